cmp_chk_mc: RTL and testbench
=============================

CMP_CHK_MC -- requirements
Module: cmp_chk_mc

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of compare channels, range 1..16.
REQ-002 SHALL provide parameter WIDTH, default 8: bits per channel, range 1..255.
REQ-003 SHALL provide parameter HOLDOFF, default 5: cycles after reset release with no comparison, range 0..255.
REQ-004 SHALL provide parameter ERR_LIMIT, default 1: error count that raises fail; 0 disables fail.
REQ-005 SHALL provide parameter CNT_W, default 32: width of all counters.
REQ-006 SHALL provide port cmp_chk_mc_clk_ip, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL provide port cmp_chk_mc_rstn_ip, input, 1: reset, synchronous, active-low.
REQ-008 SHALL provide port cmp_chk_mc_en_ip, input, 1: compare enable.
REQ-009 SHALL provide port cmp_chk_mc_clr_ip, input, 1: clear counts and fail.
REQ-010 SHALL provide port cmp_chk_mc_vld_ip, input, CHANNELS: per-channel sample valid.
REQ-011 SHALL provide port cmp_chk_mc_sig0_ip, input, CHANNELS*WIDTH: expected values; channel c at bits [c*WIDTH +: WIDTH].
REQ-012 SHALL provide port cmp_chk_mc_sig1_ip, input, CHANNELS*WIDTH: actual values, same packing.
REQ-013 SHALL provide port cmp_chk_mc_mask_ip, input, WIDTH: 1 = bit compared; shared by all channels.
REQ-014 SHALL provide port cmp_chk_mc_state_op, output, 2: HOLD=0, ACTIVE=1, FAILED=2.
REQ-015 SHALL provide port cmp_chk_mc_err_op, output, CHANNELS: registered per-channel mismatch flag.
REQ-016 SHALL provide port cmp_chk_mc_fail_op, output, 1: sticky fail.
REQ-017 SHALL provide port cmp_chk_mc_cyc_op, output, CNT_W: free-running cycle count.
REQ-018 SHALL provide port cmp_chk_mc_cmp_cnt_op, output, CNT_W: number of channel comparisons performed.
REQ-019 SHALL provide port cmp_chk_mc_err_cnt_op, output, CNT_W: number of channel mismatches.
REQ-020 SHALL provide port cmp_chk_mc_first_ch_op, output, 4: channel index of the first mismatch.
REQ-021 SHALL provide port cmp_chk_mc_first_cyc_op, output, CNT_W: cyc value at the first mismatch.

Function
REQ-022 A channel compare SHALL occur when state is ACTIVE or FAILED, en=1, clr=0 and vld[c]=1.
REQ-023 A channel mismatch SHALL be a compare with ((sig0[c]^sig1[c])&mask)!=0.
REQ-024 Inputs sampled at edge k SHALL be visible on err_op and the counters immediately after edge k (1-cycle latency).
REQ-025 err_op[c] SHALL be 1 for exactly the cycle following a mismatching sample, otherwise 0.
REQ-026 Per cycle, cmp_cnt SHALL add popcount(compares) and err_cnt SHALL add popcount(mismatches).
REQ-027 All counters SHALL saturate at all-ones and never wrap.
REQ-028 cyc SHALL increment every cycle from 0 after reset, shall saturate, and shall be unaffected by clr.
REQ-029 On the first mismatch since reset/clr, first_ch SHALL capture the lowest mismatching channel index and first_cyc the pre-increment cyc value; both then hold.
REQ-030 State HOLD SHALL count HOLDOFF cycles, then go to ACTIVE; with HOLDOFF=0 reset exits directly to ACTIVE.
REQ-031 ACTIVE SHALL go to FAILED on the edge where the updated err_cnt >= ERR_LIMIT and ERR_LIMIT!=0; fail=1 from that edge.
REQ-032 FAILED SHALL keep counting; it leaves only via clr or reset.
REQ-033 clr=1 SHALL zero cmp_cnt, err_cnt, first_*, err_op and fail, and set state to ACTIVE unless in HOLD (HOLD continues); samples in the clr cycle are discarded.
REQ-034 en=0 SHALL freeze comparisons and state transitions except the HOLD countdown.

Reset
REQ-035 With rstn=0 at an edge, the block SHALL set state=HOLD (ACTIVE if HOLDOFF=0), the holdoff counter to 0, and all outputs and counters to 0; reset overrides clr and en, including mid-operation.

Verification
REQ-036 Reset, then vld=all-ones and sig0=sig1 for 20 cycles (defaults) -> HOLD for 5 cycles, then cmp_cnt=60, err_cnt=0, fail=0.
REQ-037 Channel 2 sig1 bit0 flipped for one cycle in ACTIVE at cyc=9 -> err_op=4'b0100 for one cycle, err_cnt=1, first_ch=2, first_cyc=9, fail=1, state=FAILED.
REQ-038 Channels 1 and 3 mismatch in the same cycle with ERR_LIMIT=3 -> err_cnt=2, first_ch=1, no fail; one further mismatch -> fail.
REQ-039 Mismatch confined to bits with mask=0 -> no error; mismatch coincident with clr=1 -> discarded, counts=0, state=ACTIVE.
REQ-040 CNT_W=4 with 20 mismatching cycles -> err_cnt holds at 15; rstn=0 mid-run -> all counters 0 on the next cycle.

Source files
------------

// File: rtl/cmp_chk_mc.sv
// Multi-channel masked compare checker: per-channel mismatch flags, saturating
// cycle/compare/error counters, first-error capture and a sticky fail state.
module cmp_chk_mc #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 8,
   parameter int HOLDOFF   = 5,
   parameter int ERR_LIMIT = 1,
   parameter int CNT_W     = 32
) (
   input  logic                      cmp_chk_mc_clk_ip,
   input  logic                      cmp_chk_mc_rstn_ip,
   input  logic                      cmp_chk_mc_en_ip,
   input  logic                      cmp_chk_mc_clr_ip,
   input  logic [CHANNELS-1:0]       cmp_chk_mc_vld_ip,
   input  logic [CHANNELS*WIDTH-1:0] cmp_chk_mc_sig0_ip,
   input  logic [CHANNELS*WIDTH-1:0] cmp_chk_mc_sig1_ip,
   input  logic [WIDTH-1:0]          cmp_chk_mc_mask_ip,
   output logic [1:0]                cmp_chk_mc_state_op,
   output logic [CHANNELS-1:0]       cmp_chk_mc_err_op,
   output logic                      cmp_chk_mc_fail_op,
   output logic [CNT_W-1:0]          cmp_chk_mc_cyc_op,
   output logic [CNT_W-1:0]          cmp_chk_mc_cmp_cnt_op,
   output logic [CNT_W-1:0]          cmp_chk_mc_err_cnt_op,
   output logic [3:0]                cmp_chk_mc_first_ch_op,
   output logic [CNT_W-1:0]          cmp_chk_mc_first_cyc_op
);

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FAILED = 2'd2
   } state_t;

   state_t              state;
   logic [7:0]          hold_cnt;
   logic [CHANNELS-1:0] cmp_vec;
   logic [CHANNELS-1:0] mis_vec;
   logic [4:0]          cmp_pop;
   logic [4:0]          mis_pop;
   logic [3:0]          first_ch_nxt;
   logic [CNT_W-1:0]    cmp_cnt_nxt;
   logic [CNT_W-1:0]    err_cnt_nxt;

   // Counters clamp at all-ones; the 5 extra sum bits cover up to 16 channels.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [4:0]       b);
      logic [CNT_W+4:0] s;
      s = {5'b0, a} + {{CNT_W{1'b0}}, b};
      return (s[CNT_W+4:CNT_W] != 5'b0) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cmp_vec      = '0;
      mis_vec      = '0;
      cmp_pop      = '0;
      mis_pop      = '0;
      first_ch_nxt = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (state != ST_HOLD && cmp_chk_mc_en_ip && !cmp_chk_mc_clr_ip && cmp_chk_mc_vld_ip[c]) begin
            cmp_vec[c] = 1'b1;
            mis_vec[c] = ((cmp_chk_mc_sig0_ip[c*WIDTH +: WIDTH] ^ cmp_chk_mc_sig1_ip[c*WIDTH +: WIDTH])
                          & cmp_chk_mc_mask_ip) != '0;
         end
         cmp_pop = cmp_pop + {4'b0, cmp_vec[c]};
         mis_pop = mis_pop + {4'b0, mis_vec[c]};
      end
      // Scan downwards so the lowest mismatching channel wins.
      for (int c = CHANNELS-1; c >= 0; c--) begin
         if (mis_vec[c]) first_ch_nxt = 4'(c);
      end
      cmp_cnt_nxt = sat_add(cmp_chk_mc_cmp_cnt_op, cmp_pop);
      err_cnt_nxt = sat_add(cmp_chk_mc_err_cnt_op, mis_pop);
   end

   assign cmp_chk_mc_state_op = state;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge cmp_chk_mc_clk_ip) begin
      if (!cmp_chk_mc_rstn_ip) begin
         state                   <= (HOLDOFF == 0) ? ST_ACTIVE : ST_HOLD;
         hold_cnt                <= '0;
         cmp_chk_mc_err_op       <= '0;
         cmp_chk_mc_fail_op      <= 1'b0;
         cmp_chk_mc_cyc_op       <= '0;
         cmp_chk_mc_cmp_cnt_op   <= '0;
         cmp_chk_mc_err_cnt_op   <= '0;
         cmp_chk_mc_first_ch_op  <= '0;
         cmp_chk_mc_first_cyc_op <= '0;
      end else begin
         if (cmp_chk_mc_cyc_op != {CNT_W{1'b1}}) cmp_chk_mc_cyc_op <= cmp_chk_mc_cyc_op + 1'b1;

         // Holdoff runs regardless of en and clr.
         if (state == ST_HOLD) begin
            if (hold_cnt == 8'(HOLDOFF - 1)) state <= ST_ACTIVE;
            else                             hold_cnt <= hold_cnt + 8'd1;
         end

         if (cmp_chk_mc_clr_ip) begin
            cmp_chk_mc_err_op       <= '0;
            cmp_chk_mc_fail_op      <= 1'b0;
            cmp_chk_mc_cmp_cnt_op   <= '0;
            cmp_chk_mc_err_cnt_op   <= '0;
            cmp_chk_mc_first_ch_op  <= '0;
            cmp_chk_mc_first_cyc_op <= '0;
            if (state != ST_HOLD) state <= ST_ACTIVE;
         end else begin
            cmp_chk_mc_err_op     <= mis_vec;
            cmp_chk_mc_cmp_cnt_op <= cmp_cnt_nxt;
            cmp_chk_mc_err_cnt_op <= err_cnt_nxt;
            // A zero error count means no mismatch since reset or clear.
            if (mis_vec != '0 && cmp_chk_mc_err_cnt_op == '0) begin
               cmp_chk_mc_first_ch_op  <= first_ch_nxt;
               cmp_chk_mc_first_cyc_op <= cmp_chk_mc_cyc_op;
            end
            if (state == ST_ACTIVE && cmp_chk_mc_en_ip && ERR_LIMIT != 0 &&
                64'(err_cnt_nxt) >= 64'(ERR_LIMIT)) begin
               state              <= ST_FAILED;
               cmp_chk_mc_fail_op <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmp_chk_mc.sv
// Self-checking bench: three checker configurations share one randomized
// stimulus stream and are compared every cycle against a behavioural model.
module tb_cmp_chk_mc;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rstn, en, clr;
   logic [3:0]  vld;
   logic [31:0] sig0, sig1;
   logic [7:0]  mask;

   wire [1:0]  st_v   [N];
   wire [3:0]  err_v  [N];
   wire        fail_v [N];
   wire [31:0] cyc_v  [N];
   wire [31:0] cmp_v  [N];
   wire [31:0] ecnt_v [N];
   wire [3:0]  fch_v  [N];
   wire [31:0] fcyc_v [N];
   wire [3:0]  c_cyc, c_cmp, c_ecnt, c_fcyc;

   int hold_p [N] = '{5, 5, 0};
   int lim_p  [N] = '{1, 3, 0};
   int cw_p   [N] = '{32, 32, 4};

   // Model state, per configuration
   longint m_since [N];
   bit     m_failed[N];
   bit     m_seen  [N];
   longint m_cyc   [N];
   longint m_cmp   [N];
   longint m_ecnt  [N];
   int     m_fch   [N];
   longint m_fcyc  [N];
   bit [3:0] m_err [N];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cmp_chk_mc dut_a (
      .cmp_chk_mc_clk_ip(clk), .cmp_chk_mc_rstn_ip(rstn), .cmp_chk_mc_en_ip(en),
      .cmp_chk_mc_clr_ip(clr), .cmp_chk_mc_vld_ip(vld), .cmp_chk_mc_sig0_ip(sig0),
      .cmp_chk_mc_sig1_ip(sig1), .cmp_chk_mc_mask_ip(mask), .cmp_chk_mc_state_op(st_v[0]),
      .cmp_chk_mc_err_op(err_v[0]), .cmp_chk_mc_fail_op(fail_v[0]), .cmp_chk_mc_cyc_op(cyc_v[0]),
      .cmp_chk_mc_cmp_cnt_op(cmp_v[0]), .cmp_chk_mc_err_cnt_op(ecnt_v[0]),
      .cmp_chk_mc_first_ch_op(fch_v[0]), .cmp_chk_mc_first_cyc_op(fcyc_v[0]));

   cmp_chk_mc #(.ERR_LIMIT(3)) dut_b (
      .cmp_chk_mc_clk_ip(clk), .cmp_chk_mc_rstn_ip(rstn), .cmp_chk_mc_en_ip(en),
      .cmp_chk_mc_clr_ip(clr), .cmp_chk_mc_vld_ip(vld), .cmp_chk_mc_sig0_ip(sig0),
      .cmp_chk_mc_sig1_ip(sig1), .cmp_chk_mc_mask_ip(mask), .cmp_chk_mc_state_op(st_v[1]),
      .cmp_chk_mc_err_op(err_v[1]), .cmp_chk_mc_fail_op(fail_v[1]), .cmp_chk_mc_cyc_op(cyc_v[1]),
      .cmp_chk_mc_cmp_cnt_op(cmp_v[1]), .cmp_chk_mc_err_cnt_op(ecnt_v[1]),
      .cmp_chk_mc_first_ch_op(fch_v[1]), .cmp_chk_mc_first_cyc_op(fcyc_v[1]));

   cmp_chk_mc #(.HOLDOFF(0), .ERR_LIMIT(0), .CNT_W(4)) dut_c (
      .cmp_chk_mc_clk_ip(clk), .cmp_chk_mc_rstn_ip(rstn), .cmp_chk_mc_en_ip(en),
      .cmp_chk_mc_clr_ip(clr), .cmp_chk_mc_vld_ip(vld), .cmp_chk_mc_sig0_ip(sig0),
      .cmp_chk_mc_sig1_ip(sig1), .cmp_chk_mc_mask_ip(mask), .cmp_chk_mc_state_op(st_v[2]),
      .cmp_chk_mc_err_op(err_v[2]), .cmp_chk_mc_fail_op(fail_v[2]), .cmp_chk_mc_cyc_op(c_cyc),
      .cmp_chk_mc_cmp_cnt_op(c_cmp), .cmp_chk_mc_err_cnt_op(c_ecnt),
      .cmp_chk_mc_first_ch_op(fch_v[2]), .cmp_chk_mc_first_cyc_op(c_fcyc));

   assign cyc_v[2]  = {28'b0, c_cyc};
   assign cmp_v[2]  = {28'b0, c_cmp};
   assign ecnt_v[2] = {28'b0, c_ecnt};
   assign fcyc_v[2] = {28'b0, c_fcyc};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   // Advance the model by one clock using the current inputs, clock the DUTs,
   // then compare every output of every configuration.
   task automatic tick();
      for (int i = 0; i < N; i++) begin
         longint mx = (longint'(1) << cw_p[i]) - 1;
         if (!rstn) begin
            m_since[i] = 0; m_failed[i] = 0; m_seen[i] = 0; m_cyc[i] = 0;
            m_cmp[i] = 0; m_ecnt[i] = 0; m_fch[i] = 0; m_fcyc[i] = 0; m_err[i] = '0;
         end else begin
            bit     in_hold = (m_since[i] < hold_p[i]);
            longint pre_cyc = m_cyc[i];
            m_cyc[i]   = sat(pre_cyc + 1, mx);
            m_since[i] = m_since[i] + 1;
            if (clr) begin
               m_failed[i] = 0; m_seen[i] = 0; m_cmp[i] = 0; m_ecnt[i] = 0;
               m_fch[i] = 0; m_fcyc[i] = 0; m_err[i] = '0;
            end else begin
               int nc = 0;
               int ne = 0;
               int low = -1;
               bit [3:0] ev = '0;
               for (int c = 0; c < 4; c++) begin
                  if (!in_hold && en && vld[c]) begin
                     nc++;
                     if (((sig0[c*8 +: 8] ^ sig1[c*8 +: 8]) & mask) != 8'h00) begin
                        ne++;
                        ev[c] = 1'b1;
                        if (low < 0) low = c;
                     end
                  end
               end
               m_err[i] = ev;
               if (ne > 0 && !m_seen[i]) begin
                  m_seen[i] = 1;
                  m_fch[i]  = low;
                  m_fcyc[i] = pre_cyc;
               end
               m_cmp[i]  = sat(m_cmp[i] + nc, mx);
               m_ecnt[i] = sat(m_ecnt[i] + ne, mx);
               if (en && lim_p[i] != 0 && !m_failed[i] && m_ecnt[i] >= lim_p[i]) m_failed[i] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         int exp_st = (m_since[i] < hold_p[i]) ? 0 : (m_failed[i] ? 2 : 1);
         check($sformatf("state[%0d]", i),     64'(st_v[i]),   64'(exp_st));
         check($sformatf("err[%0d]", i),       64'(err_v[i]),  64'(m_err[i]));
         check($sformatf("fail[%0d]", i),      64'(fail_v[i]), 64'(m_failed[i]));
         check($sformatf("cyc[%0d]", i),       64'(cyc_v[i]),  64'(m_cyc[i]));
         check($sformatf("cmp_cnt[%0d]", i),   64'(cmp_v[i]),  64'(m_cmp[i]));
         check($sformatf("err_cnt[%0d]", i),   64'(ecnt_v[i]), 64'(m_ecnt[i]));
         check($sformatf("first_ch[%0d]", i),  64'(fch_v[i]),  64'(m_fch[i]));
         check($sformatf("first_cyc[%0d]", i), 64'(fcyc_v[i]), 64'(m_fcyc[i]));
      end
   endtask

   task automatic drive_equal();
      sig0 = $urandom;
      sig1 = sig0;
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; clr = 1'b0; vld = 4'hF; mask = 8'hFF;
      drive_equal();
      tick();
      tick();
      check("rst_state_a", 64'(st_v[0]), 64'd0);
      check("rst_state_c", 64'(st_v[2]), 64'd1);
      check("rst_cyc_a",   64'(cyc_v[0]), 64'd0);

      // Clean traffic: 5 holdoff cycles then 15 comparing cycles
      rstn = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         drive_equal();
         tick();
         if (k == 5) check("hold_end_a", 64'(st_v[0]), 64'd1);
         if (k == 4) check("hold_still_a", 64'(st_v[0]), 64'd0);
      end
      check("clean_cmp_a",  64'(cmp_v[0]), 64'd60);
      check("clean_ecnt_a", 64'(ecnt_v[0]), 64'd0);
      check("clean_fail_a", 64'(fail_v[0]), 64'd0);
      check("clean_cmp_c",  64'(cmp_v[2]), 64'd15);

      // Single-bit mismatch on channel 2 at cyc=9
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 9; k++) begin
         drive_equal();
         tick();
      end
      drive_equal();
      sig1[16] = ~sig1[16];
      tick();
      check("ch2_err_a",   64'(err_v[0]),  64'h4);
      check("ch2_ecnt_a",  64'(ecnt_v[0]), 64'd1);
      check("ch2_fch_a",   64'(fch_v[0]),  64'd2);
      check("ch2_fcyc_a",  64'(fcyc_v[0]), 64'd9);
      check("ch2_fail_a",  64'(fail_v[0]), 64'd1);
      check("ch2_state_a", 64'(st_v[0]),   64'd2);
      drive_equal();
      tick();
      check("ch2_err_off_a", 64'(err_v[0]), 64'h0);

      // Two mismatches in one cycle against a limit of 3, then a third
      clr = 1'b1;
      tick();
      clr = 1'b0;
      drive_equal();
      sig1[8] = ~sig1[8];
      sig1[31] = ~sig1[31];
      tick();
      check("dual_ecnt_b", 64'(ecnt_v[1]), 64'd2);
      check("dual_fch_b",  64'(fch_v[1]),  64'd1);
      check("dual_fail_b", 64'(fail_v[1]), 64'd0);
      drive_equal();
      sig1[0] = ~sig1[0];
      tick();
      check("third_fail_b", 64'(fail_v[1]), 64'd1);

      // Masked-off mismatch, then a mismatch discarded by clear
      clr = 1'b1;
      tick();
      clr = 1'b0;
      mask = 8'h0F;
      drive_equal();
      sig1[7] = ~sig1[7];
      tick();
      check("masked_err_a",  64'(err_v[0]),  64'h0);
      check("masked_ecnt_a", 64'(ecnt_v[0]), 64'd0);
      mask = 8'hFF;
      clr = 1'b1;
      drive_equal();
      sig1[0] = ~sig1[0];
      tick();
      clr = 1'b0;
      check("clrmis_ecnt_a",  64'(ecnt_v[0]), 64'd0);
      check("clrmis_cmp_a",   64'(cmp_v[0]),  64'd0);
      check("clrmis_state_a", 64'(st_v[0]),   64'd1);

      // Saturation of the 4-bit counters, then reset mid-run
      for (int k = 0; k < 20; k++) begin
         drive_equal();
         sig1[0] = ~sig1[0];
         tick();
      end
      check("sat_ecnt_c", 64'(ecnt_v[2]), 64'd15);
      rstn = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("midrst_ecnt_c", 64'(ecnt_v[2]), 64'd0);
      check("midrst_cmp_a",  64'(cmp_v[0]),  64'd0);
      check("midrst_cyc_a",  64'(cyc_v[0]),  64'd0);
      rstn = 1'b1;

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         rstn = ($urandom_range(0, 99) != 0);
         clr  = ($urandom_range(0, 29) == 0);
         en   = ($urandom_range(0, 7) != 0);
         vld  = 4'($urandom);
         mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
         sig0 = $urandom;
         sig1 = sig0;
         if ($urandom_range(0, 3) == 0) sig1 = sig1 ^ (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) sig1 = sig1 ^ (32'h1 << $urandom_range(0, 31));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
